// File: rtl/axis_fft_peak_pkg.sv
// axis_fft_peak_pkg: shared widths, m_axis_tdata field offsets and FSM state
// encoding for axis_fft_peak.
//   idx_w(n)           bin-index width for an n-bin frame
//   mag_w(c)           squared-magnitude width for c-bit signed components
//   off_*(n, c)        LSB positions of the m_axis_tdata fields
//   tdata_w(n, c)      total m_axis_tdata width
package axis_fft_peak_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned mag_w(input int unsigned c);
    return 2 * c + 1;
  endfunction

  function automatic int unsigned off_mag(input int unsigned n, input int unsigned c);
    return 0 * (n + c);
  endfunction

  function automatic int unsigned off_bin(input int unsigned n, input int unsigned c);
    return mag_w(c) + 0 * n;
  endfunction

  function automatic int unsigned off_err_long(input int unsigned n, input int unsigned c);
    return mag_w(c) + idx_w(n);
  endfunction

  function automatic int unsigned off_err_short(input int unsigned n, input int unsigned c);
    return mag_w(c) + idx_w(n) + 1;
  endfunction

  function automatic int unsigned tdata_w(input int unsigned n, input int unsigned c);
    return mag_w(c) + idx_w(n) + 2;
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: two-stage squared-magnitude pipeline (square, then sum) with the
// bin index carried alongside.
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   valid_i, data_i   complex beat {imag, real}, two's complement
//   bin_i             bin index of the beat
//   s1_valid_o        stage 1 occupied
//   valid_o, mag_o    stage 2 result: re*re + im*im, unsigned, full width
//   bin_o             bin index matching mag_o
module fft_mag_sq #(
  parameter int unsigned P_COMP_WID = 16,
  parameter int unsigned P_IDX_WID  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  input  logic [2*P_COMP_WID-1:0] data_i,
  input  logic [P_IDX_WID-1:0]    bin_i,
  output logic                    s1_valid_o,
  output logic                    valid_o,
  output logic [2*P_COMP_WID:0]   mag_o,
  output logic [P_IDX_WID-1:0]    bin_o
);

  localparam int unsigned W = P_COMP_WID;

  logic signed [2*W-1:0] re_x, im_x;
  logic signed [2*W-1:0] re_sq, im_sq;

  logic                  s1_v_q;
  logic [2*W-1:0]        sqr_q, sqi_q;
  logic [P_IDX_WID-1:0]  s1_bin_q;
  logic                  s2_v_q;
  logic [2*W:0]          mag_q;
  logic [P_IDX_WID-1:0]  s2_bin_q;

  // Sign-extend before squaring so the product is formed at full width;
  // (-2^(W-1))^2 = 2^(2W-2) still fits a 2W-bit signed result.
  assign re_x  = {{W{data_i[W-1]}}, data_i[W-1:0]};
  assign im_x  = {{W{data_i[2*W-1]}}, data_i[2*W-1:W]};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q   <= 1'b0;
      sqr_q    <= '0;
      sqi_q    <= '0;
      s1_bin_q <= '0;
      s2_v_q   <= 1'b0;
      mag_q    <= '0;
      s2_bin_q <= '0;
    end else begin
      s1_v_q   <= valid_i;
      sqr_q    <= re_sq;
      sqi_q    <= im_sq;
      s1_bin_q <= bin_i;
      s2_v_q   <= s1_v_q;
      mag_q    <= {1'b0, sqr_q} + {1'b0, sqi_q};
      s2_bin_q <= s1_bin_q;
    end
  end

  assign s1_valid_o = s1_v_q;
  assign valid_o    = s2_v_q;
  assign mag_o      = mag_q;
  assign bin_o      = s2_bin_q;

endmodule

// File: rtl/axis_fft_peak.sv
// axis_fft_peak: finds the largest |X|^2 bin of an FFT output frame on an
// AXI-Stream slave and emits {err_short, err_long, peak_bin, peak_mag} on an
// AXI-Stream master.
//   axis_clk, axis_reset_n         clock, asynchronous active-low reset
//   s_axis_tvalid/tready/tlast     input frame handshake and frame end
//   s_axis_tdata                   {imag, real}, P_COMP_WID bits each
//   m_axis_tvalid/tready           result handshake
//   m_axis_tdata                   {err_short, err_long, peak_bin, peak_mag}
// Build option: AXIS_FFT_PEAK_DC_SKIP_EN excludes bin 0 from the peak search.
module axis_fft_peak
  import axis_fft_peak_pkg::*;
#(
  parameter int unsigned P_COMP_WID       = 16,
  parameter int unsigned P_FFT_NUM_SAMPLE = 256,
  localparam int unsigned IDX = idx_w(P_FFT_NUM_SAMPLE),
  localparam int unsigned MAG = mag_w(P_COMP_WID),
  localparam int unsigned TDW = tdata_w(P_FFT_NUM_SAMPLE, P_COMP_WID)
) (
  input  logic                    axis_clk,
  input  logic                    axis_reset_n,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [2*P_COMP_WID-1:0] s_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [TDW-1:0]          m_axis_tdata
);

  state_e             state_q;
  logic               tready_q;
  logic               tvalid_q;
  logic [TDW-1:0]     tdata_q;
  logic [IDX-1:0]     idx_q;
  logic               err_short_q, err_long_q;
  logic [MAG-1:0]     peak_mag_q, peak_mag_d;
  logic [IDX-1:0]     peak_bin_q, peak_bin_d;
  logic               peak_vld_q, peak_vld_d;

  logic               accept, last_idx, frame_end;
  logic               pipe_s1_v, pipe_v;
  logic [MAG-1:0]     pipe_mag;
  logic [IDX-1:0]     pipe_bin;
  logic               cand;

  assign accept    = s_axis_tvalid & tready_q;
  assign last_idx  = (idx_q == IDX'(P_FFT_NUM_SAMPLE - 1));
  assign frame_end = accept & (s_axis_tlast | last_idx);

  fft_mag_sq #(
    .P_COMP_WID (P_COMP_WID),
    .P_IDX_WID  (IDX)
  ) u_mag (
    .clk_i      (axis_clk),
    .rst_ni     (axis_reset_n),
    .valid_i    (accept),
    .data_i     (s_axis_tdata),
    .bin_i      (idx_q),
    .s1_valid_o (pipe_s1_v),
    .valid_o    (pipe_v),
    .mag_o      (pipe_mag),
    .bin_o      (pipe_bin)
  );

  // Strict '>' keeps the lowest bin on ties; the first eligible bin loads
  // unconditionally via peak_vld_q.
  always_comb begin
    peak_mag_d = peak_mag_q;
    peak_bin_d = peak_bin_q;
    peak_vld_d = peak_vld_q;
`ifdef AXIS_FFT_PEAK_DC_SKIP_EN
    cand = pipe_v & (pipe_bin != '0);
`else
    cand = pipe_v;
`endif
    if (cand && (!peak_vld_q || (pipe_mag > peak_mag_q))) begin
      peak_mag_d = pipe_mag;
      peak_bin_d = pipe_bin;
      peak_vld_d = 1'b1;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      state_q     <= ST_ACC;
      tready_q    <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      idx_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      peak_mag_q  <= '0;
      peak_bin_q  <= '0;
      peak_vld_q  <= 1'b0;
    end else begin
      peak_mag_q <= peak_mag_d;
      peak_bin_q <= peak_bin_d;
      peak_vld_q <= peak_vld_d;
      case (state_q)
        ST_ACC: begin
          tready_q <= 1'b1;
          if (accept) begin
            idx_q <= idx_q + 1'b1;
          end
          if (frame_end) begin
            idx_q       <= '0;
            err_short_q <= s_axis_tlast & ~last_idx;
            err_long_q  <= last_idx & ~s_axis_tlast;
            tready_q    <= 1'b0;
            state_q     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Once stage 1 is empty, stage 2 holds the final beat (if any);
          // capture the result through peak_*_d so it is included.
          if (!pipe_s1_v) begin
            tvalid_q <= 1'b1;
            tdata_q  <= {err_short_q, err_long_q, peak_bin_d, peak_mag_d};
            state_q  <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (m_axis_tready) begin
            tvalid_q    <= 1'b0;
            tready_q    <= 1'b1;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            peak_mag_q  <= '0;
            peak_bin_q  <= '0;
            peak_vld_q  <= 1'b0;
            state_q     <= ST_ACC;
          end
        end
        default: begin
          state_q  <= ST_ACC;
          tready_q <= 1'b0;
          tvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_axis_fft_peak.sv
module tb_axis_fft_peak;

  localparam int W   = 16;
  localparam int N   = 256;
  localparam int MAG = 33;
  localparam int IDX = 8;
  localparam int TDW = 43;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_tvalid = 1'b0;
  logic           s_tready;
  logic           s_tlast = 1'b0;
  logic [2*W-1:0] s_tdata = '0;
  logic           m_tvalid;
  logic           m_tready = 1'b1;
  logic [TDW-1:0] m_tdata;

  int total = 0;
  int bad   = 0;

  logic signed [W-1:0] fre [0:N-1];
  logic signed [W-1:0] fim [0:N-1];

  always #5 clk = ~clk;

  axis_fft_peak #(
    .P_COMP_WID       (W),
    .P_FFT_NUM_SAMPLE (N)
  ) dut (
    .axis_clk      (clk),
    .axis_reset_n  (rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tdata  (s_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      fre[i] = '0;
      fim[i] = '0;
    end
  endtask

  // Sends beats 0..nbeats-1; tlast on beat last_at (-1: never).
  task automatic send_frame(input int nbeats, input int last_at, input int max_gap);
    for (int i = 0; i < nbeats; i++) begin
      int g;
      int to;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) begin
        @(negedge clk);
        s_tvalid = 1'b0;
      end
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = {fim[i], fre[i]};
      s_tlast  = (i == last_at);
      to = 0;
      while (!s_tready && to < 100) begin
        @(negedge clk);
        to++;
      end
      if (to >= 100) begin
        chk("accept_timeout", 64'd1, 64'd0);
        break;
      end
      @(posedge clk);
    end
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Counts falling edges after the last accepted beat until m_tvalid.
  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (m_tvalid) break;
    end
    if (!m_tvalid) chk({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic check_result(input string tag, input int ebin, input logic [63:0] emag,
                              input int es, input int el);
    logic [MAG-1:0] f_mag;
    logic [IDX-1:0] f_bin;
    f_mag = m_tdata[MAG-1:0];
    f_bin = m_tdata[MAG+IDX-1:MAG];
    chk({tag, "_bin"},   64'(f_bin), 64'(ebin));
    chk({tag, "_mag"},   64'(f_mag), emag);
    chk({tag, "_eshort"}, 64'(m_tdata[TDW-1]), 64'(es));
    chk({tag, "_elong"},  64'(m_tdata[TDW-2]), 64'(el));
  endtask

  task automatic after_consume(input string tag);
    @(negedge clk);
    chk({tag, "_rdy_back"}, 64'(s_tready), 64'd1);
    chk({tag, "_vld_drop"}, 64'(m_tvalid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [TDW-1:0] exp_d;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata",  64'(m_tdata),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_tready", 64'(s_tready), 64'd1);

    // Frame A: single peak
    clear_frame();
    fre[10] = 16'sd1000; fim[10] = -16'sd2000;
    send_frame(256, 255, 0);
    wait_result("A", lat);
    chk("A_lat", 64'(lat), 64'd3);
    check_result("A", 10, 64'd5000000, 0, 0);
    after_consume("A");

    // Frame B: tie keeps lowest bin
    clear_frame();
    fre[5] = 16'sd300;   fim[5] = 16'sd400;
    fre[200] = 16'sd300; fim[200] = 16'sd400;
    send_frame(256, 255, 0);
    wait_result("B", lat);
    check_result("B", 5, 64'd250000, 0, 0);
    after_consume("B");

    // Frame C: early tlast at index 99; bin 150 never sent
    clear_frame();
    fim[60] = 16'sd100;
    fre[150] = 16'sd5000;
    send_frame(100, 99, 0);
    wait_result("C", lat);
    chk("C_lat", 64'(lat), 64'd3);
    check_result("C", 60, 64'd10000, 1, 0);
    after_consume("C");

    // Frame D: no tlast, 257th beat stalled, result held for 20 cycles
    clear_frame();
    fre[17] = 16'sd2;
    fre[255] = 16'sd3; fim[255] = 16'sd4;
    send_frame(256, -1, 0);
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = {16'sd0, 16'sd100};
    wait_result("D", lat);
    chk("D_lat", 64'(lat), 64'd3);
    check_result("D", 255, 64'd25, 0, 1);
    exp_d = {1'b0, 1'b1, 8'd255, 33'd25};
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("D_hold_tready", 64'(s_tready), 64'd0);
      chk("D_hold_tdata",  64'(m_tdata),  64'(exp_d));
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    after_consume("D");

    // Frame E: same content as A with random valid gaps
    clear_frame();
    fre[10] = 16'sd1000; fim[10] = -16'sd2000;
    send_frame(256, 255, 3);
    wait_result("E", lat);
    chk("E_lat", 64'(lat), 64'd3);
    check_result("E", 10, 64'd5000000, 0, 0);
    after_consume("E");

    // Frame F: full-scale DC bin versus small bin 3
    clear_frame();
    fre[0] = -16'sd32768; fim[0] = -16'sd32768;
    fre[3] = 16'sd10;
    send_frame(256, 255, 0);
    wait_result("F", lat);
`ifdef AXIS_FFT_PEAK_DC_SKIP_EN
    check_result("F", 3, 64'd100, 0, 0);
`else
    check_result("F", 0, 64'd2147483648, 0, 0);
`endif
    after_consume("F");

    // Reset mid-frame, then a clean frame
    clear_frame();
    fre[20] = 16'sd1000; fim[20] = 16'sd1000;
    send_frame(50, -1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("G_rst_tready", 64'(s_tready), 64'd0);
    chk("G_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("G_rst_tdata",  64'(m_tdata),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("G_rel_tready", 64'(s_tready), 64'd1);
    clear_frame();
    fre[7] = 16'sd5; fim[7] = 16'sd5;
    send_frame(256, 255, 0);
    wait_result("G", lat);
    chk("G_lat", 64'(lat), 64'd3);
    check_result("G", 7, 64'd50, 0, 0);
    after_consume("G");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_fft_peak.md
AXIS_FFT_PEAK -- requirements
Module: axis_fft_peak

Interface
REQ-001 SHALL have parameter P_COMP_WID, default 16, signed width of each real/imag component.
REQ-002 SHALL have parameter P_FFT_NUM_SAMPLE, default 256, bins per FFT frame (power of 2, >=4).
REQ-003 SHALL port axis_clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL port axis_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL port s_axis_tvalid/s_axis_tready/s_axis_tlast  in/out/in  1 each  FFT output stream handshake and frame end.
REQ-006 SHALL port s_axis_tdata  in  2*P_COMP_WID  complex bin; real in [P_COMP_WID-1:0], imag in upper half, two's complement.
REQ-007 SHALL port m_axis_tvalid/m_axis_tready  out/in  1 each  result handshake.
REQ-008 SHALL port m_axis_tdata  out  2+IDX+MAG  {err_short, err_long, peak_bin[IDX-1:0], peak_mag[MAG-1:0]}; IDX=clog2(P_FFT_NUM_SAMPLE), MAG=2*P_COMP_WID+1.

Function
REQ-009 SHALL compute per beat mag = re*re + im*im, unsigned, MAG bits, no truncation or saturation.
REQ-010 SHALL pipeline magnitude in 2 registered stages (square, sum) with a parallel bin-index/last pipeline.
REQ-011 SHALL accept a beat only when s_axis_tvalid & s_axis_tready; bin index counts accepted beats from 0.
REQ-012 SHALL update peak when mag > stored peak (strict); ties keep the lowest bin; first compared bin loads unconditionally.
REQ-013 SHALL run FSM ACC -> DRAIN -> OUT -> ACC; s_axis_tready = 1 only in ACC.
REQ-014 SHALL end frame in ACC on accepted beat with tlast=1 or with bin index = P_FFT_NUM_SAMPLE-1, whichever first; go to DRAIN.
REQ-015 SHALL stay in DRAIN until both pipeline stages empty (2 cycles), then OUT with m_axis_tvalid=1; last beat accepted at cycle t gives m_axis_tvalid at t+3.
REQ-016 SHALL set err_short when tlast arrives with index < P_FFT_NUM_SAMPLE-1; err_long when index reaches P_FFT_NUM_SAMPLE-1 with tlast=0.
REQ-017 SHALL hold m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-018 SHALL on m_axis_tvalid & m_axis_tready return to ACC next cycle, clearing peak, index, error flags; s_axis_tready rises that cycle.
REQ-019 SHALL tolerate s_axis_tvalid gaps of any length mid-frame without changing result.
REQ-020 SHALL, after err_long, treat following beats as a new frame (no resynchronisation search).

Reset
REQ-021 SHALL on axis_reset_n=0 drive state ACC, s_axis_tready=0 while asserted and 1 first cycle after release, m_axis_tvalid=0, m_axis_tdata=0, pipeline valids 0, index 0, peak 0.
REQ-022 SHALL discard any partial frame or unconsumed result when reset asserts mid-operation.

Configuration
REQ-023 SHALL with AXIS_FFT_PEAK_DC_SKIP_EN defined exclude bin 0 from the peak search (bin 0 still counted; peak loads from bin 1).
REQ-024 SHALL without AXIS_FFT_PEAK_DC_SKIP_EN include bin 0 in the search.

Structure
REQ-025 SHALL place IDX/MAG width functions, m_axis_tdata field offsets and FSM state encoding in package axis_fft_peak_pkg.
REQ-026 SHALL implement the 2-stage squared-magnitude datapath as sub-module fft_mag_sq.

Verification
REQ-027 SHALL cover: 256-beat frame, bin 10 = (re 1000, im -2000), rest 0 -> peak_bin 10, peak_mag 5000000, errs 0, m_axis_tvalid 3 cycles after last.
REQ-028 SHALL cover: bins 5 and 200 both (re 300, im 400) -> peak_bin 5, peak_mag 250000.
REQ-029 SHALL cover: tlast at index 99 -> err_short=1, err_long=0, result from bins 0..99.
REQ-030 SHALL cover: 256 beats with no tlast, 257th beat stalled -> err_long=1; s_axis_tready=0 until result consumed.
REQ-031 SHALL cover: m_axis_tready held 0 for 20 cycles -> tdata stable, s_axis_tready 0; random s_axis_tvalid gaps -> identical result.
REQ-032 SHALL cover: bin 0 = (re -32768, im -32768), bin 3 = (re 10, im 0) -> peak_bin 0 mag 2147483648 without macro; peak_bin 3 mag 100 with AXIS_FFT_PEAK_DC_SKIP_EN; reset mid-frame -> next frame result unaffected.
